sm3_compress_core: RTL

//  Responder side of the start/end compression handshake used by the hash wrappers (seed-tree H, commitments).

---
 rtl/sm3_compress_core.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sm3_compress_core.sv
// SM3 compression function CF(V, B) responder: iterative rounds with a sliding
// 16-word message-expansion window, start/end level handshake.
`timescale 1ns/1ps
module sm3_compress_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cf_start,
    input  logic [255:0] v_in,
    input  logic [511:0] block_in,
    output logic [255:0] hash_out,
    output logic         cf_end
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t       state_q;
    logic [31:0]  st_q [8];
    logic [31:0]  st_d [8];
    logic [31:0]  w_q  [16];
    logic [31:0]  w_d  [16];
    logic [255:0] v_save_q;
    logic [6:0]   j_q;
    logic [255:0] hash_q;
    logic         cf_end_q;

    logic [5:0]   jj;
    logic [31:0]  tj, a12, ss1, ss2, ff, gg, tt1, tt2, wn;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    // UNROLL chained rounds; W'j = Wj ^ Wj+4 is read straight from the window.
    always_comb begin
        st_d = st_q;
        w_d  = w_q;
        jj   = '0;
        tj   = '0;
        a12  = '0;
        ss1  = '0;
        ss2  = '0;
        ff   = '0;
        gg   = '0;
        tt1  = '0;
        tt2  = '0;
        wn   = '0;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            jj  = j_q[5:0] + 6'(u);
            tj  = (jj < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
            a12 = rotl(st_d[0], 5'd12);
            ss1 = rotl(a12 + st_d[4] + rotl(tj, jj[4:0]), 5'd7);
            ss2 = ss1 ^ a12;
            if (jj < 6'd16) begin
                ff = st_d[0] ^ st_d[1] ^ st_d[2];
                gg = st_d[4] ^ st_d[5] ^ st_d[6];
            end else begin
                ff = (st_d[0] & st_d[1]) | (st_d[0] & st_d[2]) | (st_d[1] & st_d[2]);
                gg = (st_d[4] & st_d[5]) | (~st_d[4] & st_d[6]);
            end
            tt1 = ff + st_d[3] + ss2 + (w_d[0] ^ w_d[4]);
            tt2 = gg + st_d[7] + ss1 + w_d[0];
            wn  = p1(w_d[0] ^ w_d[7] ^ rotl(w_d[13], 5'd15)) ^ rotl(w_d[3], 5'd7) ^ w_d[10];
            st_d[3] = st_d[2];
            st_d[2] = rotl(st_d[1], 5'd9);
            st_d[1] = st_d[0];
            st_d[0] = tt1;
            st_d[7] = st_d[6];
            st_d[6] = rotl(st_d[5], 5'd19);
            st_d[5] = st_d[4];
            st_d[4] = p0(tt2);
            for (int unsigned k = 0; k < 15; k++) begin
                w_d[k] = w_d[k + 1];
            end
            w_d[15] = wn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            st_q     <= '{default: '0};
            w_q      <= '{default: '0};
            v_save_q <= '0;
            j_q      <= '0;
            hash_q   <= '0;
            cf_end_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cf_start) begin
                        v_save_q <= v_in;
                        for (int unsigned i = 0; i < 8; i++) begin
                            st_q[i] <= v_in[255 - 32*i -: 32];
                        end
                        for (int unsigned i = 0; i < 16; i++) begin
                            w_q[i] <= block_in[511 - 32*i -: 32];
                        end
                        j_q     <= '0;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // The counter reaching 64 costs one idle edge, which places
                    // completion at N + 64/UNROLL + 2.
                    if (j_q[6]) begin
                        state_q <= S_FINAL;
                    end else begin
                        st_q <= st_d;
                        w_q  <= w_d;
                        j_q  <= j_q + 7'(UNROLL);
                    end
                end
                S_FINAL: begin
                    hash_q   <= {st_q[0], st_q[1], st_q[2], st_q[3],
                                 st_q[4], st_q[5], st_q[6], st_q[7]} ^ v_save_q;
                    cf_end_q <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    if (!cf_start) begin
                        cf_end_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign hash_out = hash_q;
    assign cf_end   = cf_end_q;

endmodule
